// File: rtl/pwm_fade_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_fade_ctrl
//
// Sequences the threshold and max inputs of a bank of pwm instances. Each
// channel holds a current threshold, a target and a fade step. A
// programmable divider produces fade ticks. Every tick launches a scan that
// walks the channels one per clock through a single shared step unit, so
// each channel's current threshold moves toward its target.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   cmd_valid  command request from the CPU side
//   cmd_ready  command accepted when cmd_valid && cmd_ready (IDLE only)
//   cmd_op     0=set target+step, 1=set immediate, 2=set divider, 3=set max
//   cmd_ch     channel index for ops 0 and 1
//   cmd_value  target / immediate value / divider / max
//   cmd_step   fade step (op 0 only)
//   threshold  current thresholds, channel i at [i*WIDTH +: WIDTH]
//   max_out    period value shared by every pwm instance
//   done       per-channel level, current equals target
//   reach      per-channel one-cycle pulse when a scan lands on the target
//   busy       high while a scan is running
//   overrun    sticky, a tick arrived while a tick was already pending
// ---------------------------------------------------------------------------
module pwm_fade_ctrl #(
   parameter int WIDTH   = 16,
   parameter int CH_W    = 2,
   parameter int DEF_MAX = 1000,
   parameter int DEF_DIV = 99
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_op,
   input  logic [CH_W-1:0]               cmd_ch,
   input  logic [WIDTH-1:0]              cmd_value,
   input  logic [WIDTH-1:0]              cmd_step,
   output logic [(2**CH_W)*WIDTH-1:0]    threshold,
   output logic [WIDTH-1:0]              max_out,
   output logic [(2**CH_W)-1:0]          done,
   output logic [(2**CH_W)-1:0]          reach,
   output logic                          busy,
   output logic                          overrun
);

   localparam int CHANNELS = 2**CH_W;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                         state_q, state_d;
   logic [CH_W-1:0]                idx_q, idx_d;
   logic                           pending_q, pending_d;
   logic                           overrun_q, overrun_d;
   logic [WIDTH-1:0]               divCnt_q, divCnt_d;
   logic [WIDTH-1:0]               div_q, div_d;
   logic [WIDTH-1:0]               max_q, max_d;
   logic [CHANNELS-1:0][WIDTH-1:0] cur_q, cur_d;
   logic [CHANNELS-1:0][WIDTH-1:0] tgt_q, tgt_d;
   logic [CHANNELS-1:0][WIDTH-1:0] step_q, step_d;
   logic [CHANNELS-1:0]            reach_q, reach_d;

   logic                           tick;
   logic                           cmdAccept;
   logic                           pendingNow;
   logic [WIDTH-1:0]               selCur, selTgt, selStep, stepNext;

   assign tick      = (divCnt_q == div_q);
   assign cmdAccept = cmd_valid && (state_q == IDLE);

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q == SCAN);
   assign overrun   = overrun_q;
   assign max_out   = max_q;
   assign reach     = reach_q;
   assign threshold = cur_q;

   // Per-channel settled flag, purely a compare of current against target.
   always_comb begin
      done = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         done[i] = (cur_q[i] == tgt_q[i]);
      end
   end

   // Shared step unit for the channel under scan. The distance to the
   // target is formed first and compared against the step, so the add or
   // subtract only happens when it cannot pass the target or wrap.
   always_comb begin
      selCur   = cur_q[idx_q];
      selTgt   = tgt_q[idx_q];
      selStep  = step_q[idx_q];
      stepNext = selCur;
      if (selStep == '0) begin
         stepNext = selTgt;
      end else if (selCur < selTgt) begin
         stepNext = ((selTgt - selCur) <= selStep) ? selTgt : selCur + selStep;
      end else if (selCur > selTgt) begin
         stepNext = ((selCur - selTgt) <= selStep) ? selTgt : selCur - selStep;
      end
   end

   // Next-state logic: divider, scan sequencing with a one-deep pending
   // tick, and command decode. Commands only land in IDLE, so they never
   // collide with a scan update of the same registers.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pending_d  = pending_q;
      overrun_d  = overrun_q;
      divCnt_d   = tick ? '0 : divCnt_q + WIDTH'(1);
      div_d      = div_q;
      max_d      = max_q;
      cur_d      = cur_q;
      tgt_d      = tgt_q;
      step_d     = step_q;
      reach_d    = '0;
      pendingNow = pending_q;

      case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            // A tick that finds one already queued is lost and flagged.
            if (tick) begin
               if (pending_q) begin
                  overrun_d = 1'b1;
               end
               pendingNow = 1'b1;
            end
            pending_d     = pendingNow;
            cur_d[idx_q]  = stepNext;
            if ((selCur != selTgt) && (stepNext == selTgt)) begin
               reach_d[idx_q] = 1'b1;
            end
            idx_d = idx_q + CH_W'(1);
            if (idx_q == CH_W'(CHANNELS - 1)) begin
               if (pendingNow) begin
                  pending_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (cmdAccept) begin
         case (cmd_op)
            2'd0: begin
               tgt_d[cmd_ch]  = cmd_value;
               step_d[cmd_ch] = cmd_step;
            end
            2'd1: begin
               tgt_d[cmd_ch] = cmd_value;
               cur_d[cmd_ch] = cmd_value;
            end
            2'd2: begin
               div_d     = cmd_value;
               divCnt_d  = '0;
               overrun_d = 1'b0;
            end
            default: max_d = cmd_value;
         endcase
      end
   end

   // State register. Reset aborts any scan in flight and restores the
   // default period and divider.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         divCnt_q  <= '0;
         div_q     <= WIDTH'(DEF_DIV);
         max_q     <= WIDTH'(DEF_MAX);
         cur_q     <= '0;
         tgt_q     <= '0;
         step_q    <= '0;
         reach_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         divCnt_q  <= divCnt_d;
         div_q     <= div_d;
         max_q     <= max_d;
         cur_q     <= cur_d;
         tgt_q     <= tgt_d;
         step_q    <= step_d;
         reach_q   <= reach_d;
      end
   end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_fade_ctrl
//
// Directed bench for pwm_fade_ctrl with the default parameters. Drives
// commands through the ready/valid port, follows scans via busy and checks
// thresholds, reach pulses, stalls, overrun and reset against hand values.
// ---------------------------------------------------------------------------
module tb_pwm_fade_ctrl;

   localparam int WIDTH    = 16;
   localparam int CH_W     = 2;
   localparam int CHANNELS = 4;

   logic                        clk;
   logic                        rst;
   logic                        cmd_valid;
   logic                        cmd_ready;
   logic [1:0]                  cmd_op;
   logic [CH_W-1:0]             cmd_ch;
   logic [WIDTH-1:0]            cmd_value;
   logic [WIDTH-1:0]            cmd_step;
   logic [CHANNELS*WIDTH-1:0]   threshold;
   logic [WIDTH-1:0]            max_out;
   logic [CHANNELS-1:0]         done;
   logic [CHANNELS-1:0]         reach;
   logic                        busy;
   logic                        overrun;

   int testsRun    = 0;
   int testsFailed = 0;
   int reachCnt [CHANNELS] = '{default: 0};
   int upExp    [4] = '{30, 60, 90, 100};
   int downExp  [4] = '{150, 100, 50, 5};

   pwm_fade_ctrl #(
      .WIDTH(WIDTH), .CH_W(CH_W), .DEF_MAX(1000), .DEF_DIV(99)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_ch(cmd_ch), .cmd_value(cmd_value), .cmd_step(cmd_step),
      .threshold(threshold), .max_out(max_out), .done(done),
      .reach(reach), .busy(busy), .overrun(overrun)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count reach pulses per channel, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (reach[i] === 1'b1) reachCnt[i] = reachCnt[i] + 1;
      end
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single compare point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   function automatic logic [WIDTH-1:0] thr(input int ch);
      return threshold[ch*WIDTH +: WIDTH];
   endfunction

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for busy to reach a level; a timeout shows as a failure.
   task automatic waitBusy(input string tag, input logic level);
      int n = 0;
      while (busy !== level && n < 250) begin
         stepClk();
         n++;
      end
      checkOutput(tag, {63'd0, busy}, {63'd0, level});
   endtask

   task automatic waitScanEnd(input string tag);
      waitBusy({tag, " start"}, 1'b1);
      waitBusy({tag, " end"}, 1'b0);
   endtask

   // Present one command, hold it until accepted, then drop valid.
   task automatic applyStimulus(input logic [1:0] op, input int ch,
                                input int value, input int stp);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_ch    = CH_W'(ch);
      cmd_value = WIDTH'(value);
      cmd_step  = WIDTH'(stp);
      while (cmd_ready !== 1'b1 && n < 250) begin
         stepClk();
         n++;
      end
      checkOutput("cmd ready", {63'd0, cmd_ready}, 64'd1);
      stepClk();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int idleCycles;
      int busyCycles;
      int n;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_ch    = '0;
      cmd_value = '0;
      cmd_step  = '0;

      // Reset state
      stepClk();
      stepClk();
      checkOutput("reset threshold", threshold, 64'd0);
      checkOutput("reset max_out", max_out, 64'd1000);
      checkOutput("reset done", done, 64'hF);
      checkOutput("reset busy", busy, 64'd0);
      checkOutput("reset overrun", overrun, 64'd0);
      rst = 1'b0;
      checkOutput("ready after reset", cmd_ready, 64'd1);
      stepClk();
      checkOutput("ready first cycle", cmd_ready, 64'd1);

      // Up-ramp on channel 1
      applyStimulus(2'd2, 0, 9, 0);
      applyStimulus(2'd0, 1, 100, 30);
      for (int i = 0; i < 4; i++) begin
         waitScanEnd("up scan");
         checkOutput($sformatf("up ramp scan %0d", i), thr(1), upExp[i]);
         checkOutput($sformatf("up reach count %0d", i), reachCnt[1], (i == 3) ? 1 : 0);
      end
      waitScanEnd("up extra scan");
      checkOutput("up hold", thr(1), 64'd100);
      checkOutput("up reach once", reachCnt[1], 64'd1);
      checkOutput("up done1", done[1], 64'd1);
      checkOutput("up ch0 idle", thr(0), 64'd0);
      checkOutput("up ch2 idle", thr(2), 64'd0);
      checkOutput("up ch3 idle", thr(3), 64'd0);

      // Down-ramp on channel 2
      applyStimulus(2'd1, 2, 200, 0);
      checkOutput("down immediate", thr(2), 64'd200);
      stepClk();
      checkOutput("down immediate no reach", reachCnt[2], 64'd0);
      applyStimulus(2'd0, 2, 5, 50);
      for (int i = 0; i < 4; i++) begin
         waitScanEnd("down scan");
         checkOutput($sformatf("down ramp scan %0d", i), thr(2), downExp[i]);
      end
      checkOutput("down reach once", reachCnt[2], 64'd1);
      checkOutput("down done2", done[2], 64'd1);

      // Step 0 jumps, immediate set, max update
      applyStimulus(2'd0, 3, 777, 0);
      waitScanEnd("step0 scan");
      checkOutput("step0 ch3", thr(3), 64'd777);
      stepClk();
      checkOutput("step0 reach", reachCnt[3], 64'd1);
      applyStimulus(2'd1, 0, 500, 0);
      checkOutput("immediate ch0", thr(0), 64'd500);
      stepClk();
      checkOutput("immediate no reach", reachCnt[0], 64'd0);
      applyStimulus(2'd3, 0, 255, 0);
      checkOutput("max 255", max_out, 64'd255);

      // Command presented during a scan is stalled until IDLE
      waitBusy("stall wait busy", 1'b1);
      cmd_valid = 1'b1;
      cmd_op    = 2'd3;
      cmd_value = 16'd300;
      checkOutput("stall ready low", cmd_ready, 64'd0);
      stepClk();
      checkOutput("stall max held", max_out, 64'd255);
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         stepClk();
         n++;
      end
      checkOutput("stall accepted in idle", busy, 64'd0);
      stepClk();
      cmd_valid = 1'b0;
      checkOutput("stall max applied", max_out, 64'd300);

      // Divider 1: scans run back to back and overrun latches
      applyStimulus(2'd2, 0, 1, 0);
      waitBusy("div1 busy", 1'b1);
      idleCycles = 0;
      repeat (40) begin
         stepClk();
         if (busy !== 1'b1) idleCycles++;
      end
      checkOutput("div1 never idle", idleCycles, 64'd0);
      checkOutput("div1 overrun", overrun, 64'd1);

      // Continuous scanning never returns to IDLE, so reset to leave it
      rst = 1'b1;
      stepClk();
      rst = 1'b0;
      checkOutput("escape overrun clear", overrun, 64'd0);
      checkOutput("escape busy", busy, 64'd0);
      checkOutput("escape max default", max_out, 64'd1000);

      // Divider 20: four busy cycles in every 21
      applyStimulus(2'd2, 0, 20, 0);
      waitBusy("div20 busy", 1'b1);
      busyCycles = 0;
      repeat (84) begin
         if (busy === 1'b1) busyCycles++;
         stepClk();
      end
      checkOutput("div20 busy ratio", busyCycles, 64'd16);
      checkOutput("div20 overrun", overrun, 64'd0);

      // Reset in the middle of a scan
      applyStimulus(2'd2, 0, 9, 0);
      applyStimulus(2'd0, 1, 1000, 10);
      waitScanEnd("midreset first scan");
      checkOutput("midreset ramp start", thr(1), 64'd10);
      waitBusy("midreset second scan", 1'b1);
      stepClk();
      checkOutput("midreset busy before", busy, 64'd1);
      rst = 1'b1;
      stepClk();
      rst = 1'b0;
      checkOutput("midreset busy", busy, 64'd0);
      checkOutput("midreset ch1", thr(1), 64'd0);
      checkOutput("midreset done", done, 64'hF);
      stepClk();
      checkOutput("midreset no reach", reachCnt[1], 64'd1);
      waitScanEnd("midreset later scan");
      checkOutput("midreset ch1 stays", thr(1), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Controller that sequences the threshold and max inputs of a bank of CHANNELS pwm instances.
- Holds per-channel target and step registers, plus global period (max) and fade-divider registers.
- On every fade tick, walks all channels through one shared step unit, one channel per clock, moving each channel's current threshold toward its target.
- Sits between the CPU-side command port and the pwm bank. Its threshold bus and max_out drive the pwm instances directly.

Parameters:
WIDTH, 16, threshold/max/step width; matches pwm WIDTH
CH_W, 2, channel index width; CHANNELS = 2**CH_W
DEF_MAX, 1000, reset value of max_out
DEF_DIV, 99, reset value of the fade divider (tick every DEF_DIV+1 clocks)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=set target+step, 1=set immediate, 2=set divider, 3=set max
cmd_ch  in  CH_W  channel index (ops 0,1)
cmd_value  in  WIDTH  target / immediate value / divider / max
cmd_step  in  WIDTH  fade step (op 0 only)
threshold  out  CHANNELS*WIDTH  current thresholds; channel i at [i*WIDTH +: WIDTH]
max_out  out  WIDTH  period value for all pwm instances
done  out  CHANNELS  level: cur[i]==tgt[i]
reach  out  CHANNELS  one-cycle pulse when a scan makes cur[i] equal tgt[i]
busy  out  1  high while in SCAN
overrun  out  1  sticky: a tick arrived while SCAN already had a pending tick

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high on rst, sampled at posedge clk.

- Reset values:
  - All cur, tgt and step registers 0, so threshold=0 and done all-ones.
  - max_out=DEF_MAX, div=DEF_DIV, div_cnt=0.
  - State IDLE, idx=0, pending=0, overrun=0, reach=0, busy=0.
  - Reset asserted mid-scan aborts the scan; everything above applies on the next edge.

- FSM states: IDLE, SCAN.
  - cmd_ready = (state==IDLE), combinational; busy = (state==SCAN).

- Divider:
  - div_cnt increments every clock in both states.
  - When div_cnt==div: div_cnt<=0 and tick=1 for that cycle.

- Transitions:
  - IDLE with tick: go to SCAN, idx=0.
  - SCAN: each cycle process channel idx, then idx<=idx+1.
  - After idx==CHANNELS-1: if pending, clear pending and rescan from idx=0 (busy stays high); else go to IDLE.
  - Scan length is CHANNELS cycles.
  - Tick during SCAN: if pending already set, set overrun; then set pending (one-deep; extra ticks are lost).

- Step rule for channel idx, evaluated on the edge ending its scan cycle:
  - step==0: cur<=tgt.
  - cur<tgt: cur <= (tgt-cur <= step) ? tgt : cur+step.
  - cur>tgt: cur <= (cur-tgt <= step) ? tgt : cur-step.
  - cur==tgt: unchanged.
  - Differences are computed before adding, so there is no wrap-around. Values are unsigned; no clamping against max_out.

- reach[idx] is high for exactly the one cycle after an update that changed cur to equal tgt. It does not fire if cur already equalled tgt.

- Commands (accepted only in IDLE; one command per cycle; effect visible next cycle):
  - op0: tgt[ch]<=value, step[ch]<=cmd_step; cur unchanged.
  - op1: tgt[ch]<=value, cur[ch]<=value; no reach pulse.
  - op2: div<=value, div_cnt<=0, overrun<=0.
  - op3: max_out<=value.

- A command accepted in the same cycle as a tick in IDLE takes effect before the first scan cycle reads it.
- A command presented during SCAN is stalled until the first IDLE cycle.
- div=0 means a tick every clock: continuous back-to-back scans with overrun set.

Test Plan:
- Reset (CH_W=2, WIDTH=16): rst high 2 cycles -> all threshold fields 0, max_out=1000, done=4'b1111, busy=0; cmd_ready=1 first cycle after rst drops.
- Up-ramp: op2 value 9; op0 ch1 value 100 step 30 -> ch1 threshold after successive scans 30,60,90,100; reach[1] pulses once on 4th scan; done[1]=1 thereafter; other channels stay 0.
- Down-ramp: op1 ch2 200; op0 ch2 value 5 step 50 -> ch2 thresholds 150,100,50,5; reach[2] one pulse.
- Step 0 / immediate: op0 ch3 value 777 step 0 -> ch3=777 after one scan; op1 ch0 500 -> ch0=500 next cycle with no reach pulse; op3 value 255 -> max_out=255 next cycle.
- Stall and overrun:
  - cmd_valid held during SCAN -> cmd_ready=0; command accepted on first IDLE cycle.
  - op2 value 1 -> busy stays high continuously and overrun sets.
  - Later op2 value 20 -> overrun clears; busy is high for 4 of every 21 cycles.
- Reset mid-scan: assert rst while busy=1 with ch1 ramping -> next cycle busy=0, ch1=0, tgt cleared; no reach pulse.
